// File: rtl/spi_slave_thermo_pkg.sv
// Shared definitions for the thermostat-side SPI slave: frame width, SPI mode
// and the frame-handling FSM encoding.
package spi_slave_thermo_pkg;

    localparam int FRAME_W_DEF = 20;

    // Mode 0 only: SCLK idles low, data sampled on the rising edge.
    localparam bit SPI_CPOL = 1'b0;
    localparam bit SPI_CPHA = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } spi_state_t;

endpackage

// File: rtl/spi_slave_thermo_sync.sv
// Multi-flop synchronizer plus edge detector for one asynchronous SPI pin.
// Edges are suppressed until the pipeline has refilled after reset.
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic [SYNC_STAGES:0]   r_primed;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync   <= {SYNC_STAGES{RST_VAL}};
            r_prev   <= RST_VAL;
            r_primed <= '0;
        end else begin
            r_sync   <= {r_sync[SYNC_STAGES-2:0], i_d};
            r_prev   <= r_sync[SYNC_STAGES-1];
            r_primed <= {r_primed[SYNC_STAGES-1:0], 1'b1};
        end
    end

    // A pin already at its non-idle level when reset releases must not look
    // like an edge, so detection waits until real pin samples fill the chain.
    assign o_level = r_sync[SYNC_STAGES-1];
    assign o_rise  = r_primed[SYNC_STAGES] &  o_level & ~r_prev;
    assign o_fall  = r_primed[SYNC_STAGES] & ~o_level &  r_prev;

endmodule

// File: rtl/spi_slave_thermo.sv
// SPI mode-0 slave: oversamples SCLK/CS_N/MOSI in the clk domain, returns a
// word latched at frame start on MISO and delivers each full received frame.
module spi_slave_thermo
    import spi_slave_thermo_pkg::*;
#(
    parameter int FRAME_W     = FRAME_W_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sclk,
    input  logic               cs_n,
    input  logic               mosi,
    output logic               miso,
    output logic               miso_oe,
    input  logic [FRAME_W-1:0] tx_data,
    output logic [FRAME_W-1:0] rx_data,
    output logic               rx_valid,
    output logic               frame_err,
    output logic               busy
);

    localparam int                CNT_W    = $clog2(FRAME_W + 2);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0]  CNT_SAT  = CNT_W'(FRAME_W + 1);

    logic w_sclk_level_unused, w_sclk_rise, w_sclk_fall;
    logic w_cs_level_unused, w_cs_rise, w_cs_fall;
    logic w_mosi, w_mosi_rise_unused, w_mosi_fall_unused;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst(rst), .i_d(sclk),
        .o_level(w_sclk_level_unused), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk(clk), .rst(rst), .i_d(cs_n),
        .o_level(w_cs_level_unused), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst(rst), .i_d(mosi),
        .o_level(w_mosi), .o_rise(w_mosi_rise_unused), .o_fall(w_mosi_fall_unused)
    );

    spi_state_t         r_state, w_next;
    logic [CNT_W-1:0]   r_bit_cnt;
    logic [FRAME_W-1:0] r_tx_shift;
    logic [FRAME_W-1:0] r_rx_shift;
    logic [FRAME_W-1:0] r_rx_data;
    logic               r_rx_valid;
    logic               r_frame_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_cs_fall) w_next = ST_SHIFT;
            ST_SHIFT: if (w_cs_rise) w_next = ST_DONE;
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bit_cnt   <= '0;
            r_tx_shift  <= '0;
            r_rx_shift  <= '0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_cs_fall) begin
                        r_tx_shift <= tx_data;
                        r_rx_shift <= '0;
                        r_bit_cnt  <= '0;
                    end
                end
                // A cs_n rise in the same cycle as an sclk edge closes the
                // frame and that edge is dropped.
                ST_SHIFT: begin
                    if (!w_cs_rise) begin
                        if (w_sclk_rise) begin
                            r_rx_shift <= {r_rx_shift[FRAME_W-2:0], w_mosi};
                            if (r_bit_cnt != CNT_SAT) begin
                                r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                            end
                        end
                        if (w_sclk_fall) begin
                            r_tx_shift <= {r_tx_shift[FRAME_W-2:0], 1'b0};
                        end
                    end
                end
                ST_DONE: begin
                    if (r_bit_cnt == CNT_FULL) begin
                        r_rx_data  <= r_rx_shift;
                        r_rx_valid <= 1'b1;
                    end else begin
                        r_frame_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = (r_state == ST_SHIFT);
    assign miso_oe   = busy;
    assign miso      = busy && (r_bit_cnt < CNT_FULL) ? r_tx_shift[FRAME_W-1] : 1'b0;
    assign rx_data   = r_rx_data;
    assign rx_valid  = r_rx_valid;
    assign frame_err = r_frame_err;

endmodule

// File: tb/tb_spi_slave_thermo.sv
// Bench for spi_slave_thermo: table vectors, a reset-mid-frame sequence and
// randomized frames against a frame-level reference model.
module tb_spi_slave_thermo;

    localparam int FW = 20;
    localparam int SS = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          sclk = 1'b0;
    logic          cs_n = 1'b1;
    logic          mosi = 1'b0;
    logic [FW-1:0] tx_data = '0;
    logic          miso, miso_oe, rx_valid, frame_err, busy;
    logic [FW-1:0] rx_data;

    spi_slave_thermo #(.FRAME_W(FW), .SYNC_STAGES(SS)) dut (
        .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data), .rx_data(rx_data),
        .rx_valid(rx_valid), .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    int   cyc = 0;
    int   n_valid = 0, n_err = 0, n_bad = 0, last_valid_cyc = 0;
    logic p_valid = 1'b0, p_err = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_valid) begin
            n_valid        <= n_valid + 1;
            last_valid_cyc <= cyc;
        end
        if (frame_err) n_err <= n_err + 1;
        if ((rx_valid && p_valid) || (frame_err && p_err) || (rx_valid && frame_err))
            n_bad <= n_bad + 1;
        p_valid <= rx_valid;
        p_err   <= frame_err;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One master transaction; drives happen 3 ns after a rising clk edge so
    // cyc at the cs_n rise is the number of clk edges before it.
    task automatic run_frame(input logic [FW-1:0] w, input int nbits,
                             input logic [FW-1:0] tx, input logic [FW-1:0] tx2,
                             input int gap_ns, input logic ev, input logic ee,
                             input logic [FW-1:0] erx, input string tag);
        int          v0, e0, cs_cyc;
        logic [23:0] cap, expc;
        v0 = n_valid;
        e0 = n_err;
        cap = '0;
        expc = '0;
        for (int i = 0; i < nbits; i++)
            if (i < FW) expc[23-i] = tx[FW-1-i];

        tx_data = tx;
        cs_n = 1'b0;
        mosi = w[FW-1];
        #40;
        check({tag, "_busy_oe_first"}, {30'd0, busy, miso_oe}, 32'h3);
        check({tag, "_miso_first"}, {31'd0, miso}, {31'd0, tx[FW-1]});
        #10;
        for (int i = 0; i < nbits; i++) begin
            sclk = 1'b1;
            cap[23-i] = miso;
            #50;
            sclk = 1'b0;
            if (i == 4) tx_data = tx2;
            if (i + 1 < FW) mosi = w[FW-2-i];
            else            mosi = 1'b0;
            #50;
        end
        cs_n = 1'b1;
        cs_cyc = cyc;
        #48;
        check({tag, "_rx_data"}, {12'd0, rx_data}, {12'd0, erx});
        check({tag, "_valid_cnt"}, n_valid - v0, ev ? 1 : 0);
        check({tag, "_err_cnt"}, n_err - e0, ee ? 1 : 0);
        check({tag, "_miso_word"}, {8'd0, cap}, {8'd0, expc});
        check({tag, "_busy_after"}, {30'd0, busy, miso_oe}, 32'h0);
        if (ev) check({tag, "_latency"}, last_valid_cyc - cs_cyc, SS + 2);
        #(gap_ns - 48);
    endtask

    typedef struct {
        logic [FW-1:0] w;
        int            nbits;
        logic [FW-1:0] tx;
        logic [FW-1:0] tx2;
        int            gap;
        logic          ev;
        logic          ee;
        logic [FW-1:0] erx;
    } vec_t;

    vec_t        tbl[7];
    logic [FW-1:0] m_rx;

    initial begin
        int v0, e0;
        tbl[0] = '{20'd5,       20, 20'h12345, 20'h12345, 80, 1'b1, 1'b0, 20'd5};
        tbl[1] = '{20'd35,      20, 20'hABCDE, 20'hABCDE, 80, 1'b1, 1'b0, 20'd35};
        tbl[2] = '{20'd6,       20, 20'h00000, 20'h00000, 80, 1'b1, 1'b0, 20'd6};
        tbl[3] = '{20'hFFFFF,    7, 20'h55555, 20'h55555, 80, 1'b0, 1'b1, 20'd6};
        tbl[4] = '{20'd50,      22, 20'hF0F0F, 20'hF0F0F, 80, 1'b0, 1'b1, 20'd6};
        tbl[5] = '{20'd222,     20, 20'h13579, 20'h2468A, 50, 1'b1, 1'b0, 20'd222};
        tbl[6] = '{20'd333,     20, 20'hFEDCB, 20'h00000, 80, 1'b1, 1'b0, 20'd333};

        #20;
        check("reset_outputs", {8'd0, miso, miso_oe, busy, rx_valid, frame_err, 2'd0, rx_data},
              32'd0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #100;

        for (int k = 0; k < 7; k++)
            run_frame(tbl[k].w, tbl[k].nbits, tbl[k].tx, tbl[k].tx2, tbl[k].gap,
                      tbl[k].ev, tbl[k].ee, tbl[k].erx, $sformatf("vec%0d", k));

        // Reset in the middle of a frame, with cs_n still low at release.
        v0 = n_valid;
        e0 = n_err;
        tx_data = 20'hFFFFF;
        cs_n = 1'b0;
        mosi = 1'b1;
        #50;
        for (int i = 0; i < 10; i++) begin
            sclk = 1'b1; #50;
            sclk = 1'b0; mosi = ~mosi; #50;
        end
        rst = 1'b0;
        #1;
        check("midreset_outputs", {8'd0, miso, miso_oe, busy, rx_valid, frame_err, 2'd0, rx_data},
              32'd0);
        #19;
        rst = 1'b1;
        #100;
        check("midreset_cs_low_no_start", {31'd0, busy}, 32'd0);
        cs_n = 1'b1;
        #100;
        check("midreset_no_pulses", (n_valid - v0) + (n_err - e0), 0);
        m_rx = '0;
        run_frame(20'd111, 20, 20'h0F0F0, 20'h0F0F0, 80, 1'b1, 1'b0, 20'd111, "after_reset");
        m_rx = 20'd111;

        for (int k = 0; k < 25; k++) begin
            logic [FW-1:0] w, tx, tx2;
            int            nb;
            w   = FW'($urandom);
            tx  = FW'($urandom);
            tx2 = FW'($urandom);
            nb  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 23) : FW;
            if (nb == FW) m_rx = w;
            run_frame(w, nb, tx, tx2, ($urandom_range(0, 1) == 0) ? 50 : 80,
                      nb == FW, nb != FW, m_rx, $sformatf("rnd%0d", k));
        end

        #100;
        check("pulse_width_exclusive", n_bad, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
